// File: rtl/boundary_edge.sv
`default_nettype none
// ============================================================================
// Module   : boundary_edge
// Purpose  : Ghost-cell register bank for one grid edge. Values come from a
//            serial init chain and update on each simulation tick according
//            to the selected boundary mode (Dirichlet, Neumann, periodic,
//            absorbing).
// Revision : 1.0 - initial release
// ============================================================================
module boundary_edge #(
    parameter int WIDTH       = 8,
    parameter int CELLS       = 4,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Tick,
    input  logic [1:0]             Mode,
    input  logic                   InitLoad,
    input  logic [WIDTH-1:0]       InitIn,
    output logic [WIDTH-1:0]       InitOut,
    input  logic [CELLS*WIDTH-1:0] Interior,
    input  logic [CELLS*WIDTH-1:0] Opposite,
    output logic [CELLS*WIDTH-1:0] GC_VAL,
    output logic                   InitDone,
    output logic [15:0]            StepCount
);

    localparam int                  C_LCNT_W = $clog2(CELLS + 1);
    localparam logic [C_LCNT_W-1:0] C_CELLS  = C_LCNT_W'(CELLS);
    localparam logic [C_LCNT_W-1:0] C_ONE    = C_LCNT_W'(1);

    localparam logic [1:0] C_MODE_DIRICHLET = 2'd0;
    localparam logic [1:0] C_MODE_NEUMANN   = 2'd1;
    localparam logic [1:0] C_MODE_PERIODIC  = 2'd2;
    localparam logic [1:0] C_MODE_ABSORB    = 2'd3;

    logic [WIDTH-1:0]    r_init [CELLS];
    logic [WIDTH-1:0]    r_gc   [CELLS];
    logic [C_LCNT_W-1:0] r_lcnt;
    logic [15:0]         r_stepCount;

    logic                w_initDone;
    logic                w_tickAccept;
    logic [WIDTH-1:0]    w_decayed [CELLS];

    // A complete sequence is present exactly when the load counter is full.
    assign w_initDone   = (r_lcnt == C_CELLS);
    // Loading takes priority: a tick on a load edge is dropped, not deferred.
    assign w_tickAccept = Tick & ~InitLoad & w_initDone;

    assign InitDone  = w_initDone;
    assign InitOut   = r_init[CELLS-1];
    assign StepCount = r_stepCount;

    // Per-cell absorbing step: subtract GC>>DECAY_SHIFT, or 1 once the shift
    // rounds to zero so small values still drain to 0 without underflow.
    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        logic [WIDTH-1:0] w_shifted;
        logic [WIDTH-1:0] w_delta;

        assign w_shifted    = r_gc[i] >> DECAY_SHIFT;
        assign w_delta      = (w_shifted != '0) ? w_shifted :
                              ((r_gc[i] != '0) ? WIDTH'(1) : '0);
        assign w_decayed[i] = r_gc[i] - w_delta;
        assign GC_VAL[i*WIDTH +: WIDTH] = r_gc[i];
    end

    // Serial init chain and load counter; a load while full restarts the count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CELLS; i++) begin
                r_init[i] <= '0;
            end
            r_lcnt <= '0;
        end else if (InitLoad) begin
            r_init[0] <= InitIn;
            for (int i = 1; i < CELLS; i++) begin
                r_init[i] <= r_init[i-1];
            end
            r_lcnt <= w_initDone ? C_ONE : (r_lcnt + C_ONE);
        end
    end

    // Ghost-cell update on each accepted tick, mode sampled on that edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CELLS; i++) begin
                r_gc[i] <= '0;
            end
        end else if (w_tickAccept) begin
            for (int i = 0; i < CELLS; i++) begin
                case (Mode)
                    C_MODE_DIRICHLET: r_gc[i] <= r_init[i];
                    C_MODE_NEUMANN:   r_gc[i] <= Interior[i*WIDTH +: WIDTH];
                    C_MODE_PERIODIC:  r_gc[i] <= Opposite[i*WIDTH +: WIDTH];
                    C_MODE_ABSORB:    r_gc[i] <= w_decayed[i];
                    default:          r_gc[i] <= r_gc[i];
                endcase
            end
        end
    end

    // Accepted-tick counter, free-running wrap at 16 bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_stepCount <= '0;
        end else if (w_tickAccept) begin
            r_stepCount <= r_stepCount + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boundary_edge.sv
`default_nettype none
// ============================================================================
// Module   : tb_boundary_edge
// Purpose  : Self-checking bench for boundary_edge (WIDTH=8, CELLS=4,
//            DECAY_SHIFT=2) using a behavioural model and an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boundary_edge;

    localparam int WIDTH = 8;
    localparam int CELLS = 4;
    localparam int DECAY_SHIFT = 2;

    logic        clk;
    logic        clkEn;
    logic        rstN;
    logic        tick;
    logic [1:0]  mode;
    logic        initLoad;
    logic [7:0]  initIn;
    logic [7:0]  initOut;
    logic [31:0] interior;
    logic [31:0] opposite;
    logic [31:0] gcVal;
    logic        initDone;
    logic [15:0] stepCount;

    typedef struct {
        logic [31:0] gc;
        logic [15:0] step;
        logic [7:0]  initOut;
        logic        done;
    } exp_t;

    exp_t sbQ[$];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int mInit [CELLS];
    int mGc   [CELLS];
    int mLcnt;
    int mStep;

    boundary_edge #(
        .WIDTH(WIDTH),
        .CELLS(CELLS),
        .DECAY_SHIFT(DECAY_SHIFT)
    ) dut (
        .Clk(clk),
        .Reset(rstN),
        .Tick(tick),
        .Mode(mode),
        .InitLoad(initLoad),
        .InitIn(initIn),
        .InitOut(initOut),
        .Interior(interior),
        .Opposite(opposite),
        .GC_VAL(gcVal),
        .InitDone(initDone),
        .StepCount(stepCount)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clkEn) clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decayNext(input int v);
        int d;
        d = v / (1 << DECAY_SHIFT);
        if (d == 0) d = (v != 0) ? 1 : 0;
        return v - d;
    endfunction

    function automatic logic [31:0] packGc();
        logic [31:0] p;
        for (int i = 0; i < CELLS; i++) p[i*8 +: 8] = mGc[i][7:0];
        return p;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < CELLS; i++) begin
            mInit[i] = 0;
            mGc[i]   = 0;
        end
        mLcnt = 0;
        mStep = 0;
    endtask

    // One clock: drive at negedge, advance model, queue expectation, then
    // compare the DUT just after the rising edge.
    task automatic doCycle(input logic t, input logic ld, input logic [7:0] din, input logic [1:0] md);
        exp_t e;
        exp_t g;
        logic acc;
        @(negedge clk);
        tick = t; initLoad = ld; initIn = din; mode = md;
        acc = t && !ld && (mLcnt == CELLS);
        if (acc) begin
            for (int i = 0; i < CELLS; i++) begin
                case (md)
                    2'd0: mGc[i] = mInit[i];
                    2'd1: mGc[i] = int'(interior[i*8 +: 8]);
                    2'd2: mGc[i] = int'(opposite[i*8 +: 8]);
                    default: mGc[i] = decayNext(mGc[i]);
                endcase
            end
            mStep = (mStep + 1) % 65536;
        end
        if (ld) begin
            for (int i = CELLS - 1; i > 0; i--) mInit[i] = mInit[i-1];
            mInit[0] = int'(din);
            mLcnt = (mLcnt == CELLS) ? 1 : mLcnt + 1;
        end
        e.gc = packGc();
        e.step = mStep[15:0];
        e.initOut = mInit[CELLS-1][7:0];
        e.done = (mLcnt == CELLS);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        g = sbQ.pop_front();
        checkValue("gc_val", gcVal, g.gc);
        checkValue("step_count", {16'd0, stepCount}, {16'd0, g.step});
        checkValue("init_out", {24'd0, initOut}, {24'd0, g.initOut});
        checkValue("init_done", {31'd0, initDone}, {31'd0, g.done});
        tick = 1'b0; initLoad = 1'b0;
    endtask

    int decaySeq [19] = '{90, 68, 51, 39, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0};

    initial begin
        clkEn = 1'b0;
        rstN = 1'b1; tick = 1'b0; mode = 2'd0; initLoad = 1'b0; initIn = 8'd0;
        interior = 32'd0; opposite = 32'd0;
        modelReset();

        // 1: asynchronous reset with clock stopped
        #2 rstN = 1'b0;
        #1;
        checkValue("rst_gc", gcVal, 32'd0);
        checkValue("rst_initout", {24'd0, initOut}, 32'd0);
        checkValue("rst_done", {31'd0, initDone}, 32'd0);
        checkValue("rst_step", {16'd0, stepCount}, 32'd0);
        #5 clkEn = 1'b1;
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) doCycle(1'b1, 1'b0, 8'h00, 2'd0);
        checkValue("tick_before_load", {16'd0, stepCount}, 32'd0);

        // 2: load chain, then Dirichlet
        doCycle(1'b0, 1'b1, 8'h11, 2'd0);
        doCycle(1'b0, 1'b1, 8'h22, 2'd0);
        doCycle(1'b0, 1'b1, 8'h33, 2'd0);
        checkValue("done_before_4th", {31'd0, initDone}, 32'd0);
        doCycle(1'b0, 1'b1, 8'h44, 2'd0);
        checkValue("done_on_4th", {31'd0, initDone}, 32'd1);
        checkValue("initout_first", {24'd0, initOut}, 32'h11);
        doCycle(1'b1, 1'b0, 8'h00, 2'd0);
        checkValue("dirichlet", gcVal, 32'h11223344);
        checkValue("step_1", {16'd0, stepCount}, 32'd1);

        // 3: Neumann and periodic
        interior = 32'h5A5A5A5A;
        doCycle(1'b1, 1'b0, 8'h00, 2'd1);
        checkValue("neumann", gcVal, 32'h5A5A5A5A);
        checkValue("step_2", {16'd0, stepCount}, 32'd2);
        opposite = 32'h13121110;
        doCycle(1'b0, 1'b0, 8'h00, 2'd3);   // mode change without tick: no effect
        checkValue("mode_no_tick", gcVal, 32'h5A5A5A5A);
        doCycle(1'b1, 1'b0, 8'h00, 2'd2);
        checkValue("periodic", gcVal, 32'h13121110);

        // 4: absorbing decay from 0x5A on consecutive ticks
        doCycle(1'b1, 1'b0, 8'h00, 2'd1);
        for (int k = 1; k < 19; k++) begin
            doCycle(1'b1, 1'b0, 8'h00, 2'd3);
            checkValue("decay_seq", {24'd0, gcVal[7:0]}, decaySeq[k]);
        end

        // 5: tick during load is dropped; reload gate
        doCycle(1'b1, 1'b0, 8'h00, 2'd0);   // restore INIT values
        doCycle(1'b1, 1'b1, 8'hA1, 2'd1);
        checkValue("tick_with_load_gc", gcVal, 32'h11223344);
        checkValue("reload_drops_done", {31'd0, initDone}, 32'd0);
        doCycle(1'b1, 1'b0, 8'h00, 2'd1);   // ignored, not done
        doCycle(1'b0, 1'b1, 8'hA2, 2'd0);
        doCycle(1'b1, 1'b1, 8'hA3, 2'd1);
        doCycle(1'b1, 1'b0, 8'h00, 2'd1);   // still ignored
        doCycle(1'b0, 1'b1, 8'hA4, 2'd0);
        checkValue("reload_done", {31'd0, initDone}, 32'd1);
        doCycle(1'b1, 1'b0, 8'h00, 2'd0);
        checkValue("reload_dirichlet", gcVal, 32'hA1A2A3A4);

        // 6: StepCount wrap, then async reset during decay
        while (mStep != 65535) doCycle(1'b1, 1'b0, 8'h00, 2'd1);
        checkValue("step_ffff", {16'd0, stepCount}, 32'hFFFF);
        doCycle(1'b1, 1'b0, 8'h00, 2'd1);
        checkValue("step_wrap", {16'd0, stepCount}, 32'd0);
        doCycle(1'b1, 1'b0, 8'h00, 2'd3);
        doCycle(1'b1, 1'b0, 8'h00, 2'd3);
        #2 rstN = 1'b0;
        #1;
        modelReset();
        checkValue("midrun_rst_gc", gcVal, 32'd0);
        checkValue("midrun_rst_step", {16'd0, stepCount}, 32'd0);
        checkValue("midrun_rst_done", {31'd0, initDone}, 32'd0);
        checkValue("midrun_rst_initout", {24'd0, initOut}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        doCycle(1'b1, 1'b0, 8'h00, 2'd0);   // ticks ignored after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
